// File: rtl/verin_pkg.sv
// Shared definitions for the verin PWM generator.
//   - Avalon register addresses (CTRL / PERIOD / DUTY / STATUS)
//   - CTRL and STATUS bit positions
//   - FSM state encoding and the CTRL register layout
package verin_pkg;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PERIOD = 2'd1;
  localparam logic [1:0] ADDR_DUTY   = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  localparam int CTRL_RUN_BIT  = 0;
  localparam int CTRL_DIR_BIT  = 1;

  localparam int STAT_RUN_BIT  = 0;
  localparam int STAT_DEAD_BIT = 1;
  localparam int STAT_EN_BIT   = 2;
  localparam int STAT_DONE_BIT = 3;
  localparam int STAT_CNT_LSB  = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DEAD = 2'd2
  } state_e;

  // Bit order matches the CTRL register: bit1 dir, bit0 run.
  typedef struct packed {
    logic dir;
    logic run;
  } ctrl_t;

endpackage

// File: rtl/verin_pwm_core.sv
// PWM engine: period counter, period/duty shadows, compare and run/dead-time FSM.
// Ports:
//   clk, reset_n  clock, asynchronous active-low reset
//   go_i          run permission (run bit && enable_in && PERIOD != 0)
//   dir_req_i     direction requested by software
//   period_i      live PERIOD register, sampled only at period boundaries
//   duty_i        live DUTY register, sampled only at period boundaries
//   state_o       current FSM state
//   cnt_o         current position within the period
//   wrap_o        one-cycle strobe: the counter wraps on the coming edge
//   pwm_o         registered PWM drive
//   dir_o         registered direction drive
module verin_pwm_core
  import verin_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int DEADTIME = 50
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             go_i,
  input  logic             dir_req_i,
  input  logic [CNT_W-1:0] period_i,
  input  logic [CNT_W-1:0] duty_i,
  output state_e           state_o,
  output logic [CNT_W-1:0] cnt_o,
  output logic             wrap_o,
  output logic             pwm_o,
  output logic             dir_o
);

  localparam int DW = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;
  localparam logic [DW-1:0] DEAD_LOAD = DW'(DEADTIME - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] per_sh_q;
  logic [CNT_W-1:0] duty_sh_q;
  logic [DW-1:0]    dead_q;
  logic             pwm_q;
  logic             dir_q;

  logic [CNT_W-1:0] cnt_inc_d;
  logic             last_d;
  logic             dir_match_d;

  // cnt_q never exceeds per_sh_q-1 while running, so the increment cannot overflow.
  assign cnt_inc_d   = cnt_q + 1'b1;
  assign last_d      = (cnt_inc_d == per_sh_q);
  assign dir_match_d = (dir_req_i == dir_q);
  assign wrap_o      = (state_q == ST_RUN) && go_i && dir_match_d && last_d;

  // pwm_q is computed from the values the counter/shadows take on the same edge,
  // so pwm_o always matches the state and count visible in STATUS.
  // NOTE: every register in this block uses non-blocking assignment so all of
  // them see the pre-edge values, regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      per_sh_q  <= '0;
      duty_sh_q <= '0;
      dead_q    <= '0;
      pwm_q     <= 1'b0;
      dir_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (go_i) begin
            if (dir_match_d) begin
              state_q   <= ST_RUN;
              cnt_q     <= '0;
              per_sh_q  <= period_i;
              duty_sh_q <= duty_i;
              pwm_q     <= (duty_i != '0);
            end else begin
              state_q <= ST_DEAD;
              dead_q  <= DEAD_LOAD;
            end
          end
        end
        ST_RUN: begin
          if (!go_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pwm_q   <= 1'b0;
          end else if (!dir_match_d) begin
            state_q <= ST_DEAD;
            dead_q  <= DEAD_LOAD;
            cnt_q   <= '0;
            pwm_q   <= 1'b0;
          end else if (last_d) begin
            cnt_q     <= '0;
            per_sh_q  <= period_i;
            duty_sh_q <= duty_i;
            pwm_q     <= (duty_i != '0);
          end else begin
            cnt_q <= cnt_inc_d;
            pwm_q <= (cnt_inc_d < duty_sh_q);
          end
        end
        ST_DEAD: begin
          // A direction flip during dead-time does not restart the count; the
          // request present at expiry is the one applied.
          if (!go_i) begin
            state_q <= ST_IDLE;
          end else if (dead_q == '0) begin
            dir_q     <= dir_req_i;
            state_q   <= ST_RUN;
            cnt_q     <= '0;
            per_sh_q  <= period_i;
            duty_sh_q <= duty_i;
            pwm_q     <= (duty_i != '0);
          end else begin
            dead_q <= dead_q - 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
          pwm_q   <= 1'b0;
        end
      endcase
    end
  end

  assign state_o = state_q;
  assign cnt_o   = cnt_q;
  assign pwm_o   = pwm_q;
  assign dir_o   = dir_q;

endmodule

// File: rtl/verin_pwm_gen.sv
// Avalon-MM slave PWM generator for the actuator power stage.
// Holds the CTRL/PERIOD/DUTY registers, the sticky period_done flag and the
// zero-wait-state read mux; the waveform itself comes from verin_pwm_core.
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   address               0 CTRL, 1 PERIOD, 2 DUTY, 3 STATUS
//   chipselect, write_n   write = chipselect && !write_n
//   writedata, readdata   32-bit data; readdata is combinational on address
//   enable_in             run permission from the LED PIO
//   pwm_out, dir_out      registered drives to the power stage
module verin_pwm_gen
  import verin_pkg::*;
#(
  parameter int CNT_W      = 16,
  parameter int DEADTIME   = 50,
  parameter int PERIOD_RST = 1000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        enable_in,
  output logic        pwm_out,
  output logic        dir_out
);

  ctrl_t            ctrl_q;
  logic [CNT_W-1:0] period_q;
  logic [CNT_W-1:0] duty_q;
  logic             done_q;

  logic             wr_en;
  logic             go;
  logic             wrap;
  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic             unused_wdata;

  assign wr_en        = chipselect && !write_n;
  assign go           = ctrl_q.run && enable_in && (period_q != '0);
  assign unused_wdata = ^writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q   <= '0;
      period_q <= CNT_W'(PERIOD_RST);
      duty_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      if (wr_en) begin
        case (address)
          ADDR_CTRL:   ctrl_q   <= ctrl_t'(writedata[1:0]);
          ADDR_PERIOD: period_q <= writedata[CNT_W-1:0];
          ADDR_DUTY:   duty_q   <= writedata[CNT_W-1:0];
          default:     ;
        endcase
      end
      // A wrap on the same edge as a write-1-clear keeps the flag set.
      if (wrap) begin
        done_q <= 1'b1;
      end else if (wr_en && (address == ADDR_STATUS) && writedata[STAT_DONE_BIT]) begin
        done_q <= 1'b0;
      end
    end
  end

  verin_pwm_core #(
    .CNT_W    (CNT_W),
    .DEADTIME (DEADTIME)
  ) u_core (
    .clk       (clk),
    .reset_n   (reset_n),
    .go_i      (go),
    .dir_req_i (ctrl_q.dir),
    .period_i  (period_q),
    .duty_i    (duty_q),
    .state_o   (state),
    .cnt_o     (cnt),
    .wrap_o    (wrap),
    .pwm_o     (pwm_out),
    .dir_o     (dir_out)
  );

  // NOTE: readdata gets a default before the case so no path leaves it unassigned,
  // which keeps this block purely combinational.
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_CTRL: begin
        readdata[CTRL_RUN_BIT] = ctrl_q.run;
        readdata[CTRL_DIR_BIT] = ctrl_q.dir;
      end
      ADDR_PERIOD: readdata = 32'(period_q);
      ADDR_DUTY:   readdata = 32'(duty_q);
      default: begin
        readdata                = 32'(cnt) << STAT_CNT_LSB;
        readdata[STAT_RUN_BIT]  = (state == ST_RUN);
        readdata[STAT_DEAD_BIT] = (state == ST_DEAD);
        readdata[STAT_EN_BIT]   = enable_in;
        readdata[STAT_DONE_BIT] = done_q;
      end
    endcase
  end

endmodule

// File: tb/tb_verin_pwm_gen.sv
// Self-checking bench for verin_pwm_gen: register table, hand-written corner
// sequences, then randomized traffic against a behavioural model.
module tb_verin_pwm_gen;
  import verin_pkg::*;

  localparam int CNT_W      = 16;
  localparam int DEADTIME   = 50;
  localparam int PERIOD_RST = 1000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        enable_in;
  logic        pwm_out;
  logic        dir_out;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  verin_pwm_gen #(
    .CNT_W      (CNT_W),
    .DEADTIME   (DEADTIME),
    .PERIOD_RST (PERIOD_RST)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .enable_in  (enable_in),
    .pwm_out    (pwm_out),
    .dir_out    (dir_out)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance one clock; afterwards any write strobe is released and readdata shows STATUS.
  task automatic tick();
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    address    = ADDR_STATUS;
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    tick();
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    address = a;
    #1;
    d = readdata;
    address = ADDR_STATUS;
    #1;
  endtask

  task automatic wait_cnt(input int target, input int budget);
    int n;
    n = 0;
    while ((32'(readdata[31:16]) != target) && (n < budget)) begin
      tick();
      n++;
    end
    check("wait_cnt reached", 32'(readdata[31:16]), 32'(target));
  endtask

  // Expects DEAD to start within a few cycles, then checks its length and the restart.
  task automatic measure_dead(input string tag, input logic old_dir, input logic new_dir,
                              input int toggle_at, input logic [31:0] toggle_ctrl);
    int n;
    int guard;
    n = 0;
    guard = 0;
    while ((readdata[STAT_DEAD_BIT] !== 1'b1) && (guard < 5)) begin
      tick();
      guard++;
    end
    check({tag, " dead entered"}, 32'(readdata[STAT_DEAD_BIT]), 32'd1);
    while ((readdata[STAT_DEAD_BIT] === 1'b1) && (n < 4 * DEADTIME)) begin
      check({tag, " pwm low in dead"}, 32'(pwm_out), 32'd0);
      check({tag, " dir held in dead"}, 32'(dir_out), 32'(old_dir));
      if (n == toggle_at) begin
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = ADDR_CTRL;
        writedata  = toggle_ctrl;
      end
      tick();
      n++;
    end
    check({tag, " dead length"}, 32'(n), 32'(DEADTIME));
    check({tag, " dir after dead"}, 32'(dir_out), 32'(new_dir));
    check({tag, " state after dead"}, 32'(readdata[1:0]), 32'd1);
    check({tag, " cnt after dead"}, 32'(readdata[31:16]), 32'd0);
    check({tag, " pwm after dead"}, 32'(pwm_out), 32'd1);
  endtask

  // ---------------- behavioural model for the random phase ----------------
  int unsigned m_mode;       // 0 stopped, 1 pulsing, 2 dead time
  int unsigned m_pos;        // position in current period
  int unsigned m_len;        // length of current period
  int unsigned m_high;       // high cycles of current period
  int unsigned m_dead_left;  // dead cycles still to serve, including the current one
  int unsigned m_period;
  int unsigned m_duty;
  bit          m_run;
  bit          m_dirreq;
  bit          m_dir;
  bit          m_done;

  task automatic model_reset();
    m_mode = 0; m_pos = 0; m_len = 0; m_high = 0; m_dead_left = 0;
    m_period = PERIOD_RST; m_duty = 0;
    m_run = 1'b0; m_dirreq = 1'b0; m_dir = 1'b0; m_done = 1'b0;
  endtask

  task automatic model_start_period();
    m_mode = 1;
    m_pos  = 0;
    m_len  = m_period;
    m_high = m_duty;
  endtask

  // One clock edge with the given bus/enable inputs present before it.
  task automatic model_step(input bit w, input logic [1:0] a, input logic [31:0] d, input bit en);
    bit go;
    bit wrapped;
    go = m_run && en && (m_period != 0);
    wrapped = 1'b0;
    if (!go) begin
      m_mode = 0;
      m_pos  = 0;
    end else if (m_mode == 0) begin
      if (m_dirreq == m_dir) model_start_period();
      else begin m_mode = 2; m_dead_left = DEADTIME; end
    end else if (m_mode == 1) begin
      if (m_dirreq != m_dir) begin
        m_mode = 2; m_dead_left = DEADTIME; m_pos = 0;
      end else if (m_pos + 1 == m_len) begin
        model_start_period();
        wrapped = 1'b1;
      end else begin
        m_pos++;
      end
    end else begin
      m_dead_left--;
      if (m_dead_left == 0) begin
        m_dir = m_dirreq;
        model_start_period();
      end
    end
    if (wrapped) m_done = 1'b1;
    else if (w && (a == ADDR_STATUS) && d[3]) m_done = 1'b0;
    if (w) begin
      case (a)
        ADDR_CTRL:   begin m_run = d[0]; m_dirreq = d[1]; end
        ADDR_PERIOD: m_period = d & 32'hFFFF;
        ADDR_DUTY:   m_duty   = d & 32'hFFFF;
        default:     ;
      endcase
    end
  endtask

  // ---------------- register table ----------------
  typedef struct {
    string       name;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } reg_vec_t;

  reg_vec_t vecs[7];

  initial begin
    logic [31:0] got;
    logic [31:0] ctrl_d;
    logic [31:0] d;
    logic [1:0]  a;
    bit          w;
    bit          en;
    int          exp_duty;

    vecs[0] = '{"ctrl all ones",    ADDR_CTRL,   32'hFFFF_FFFF, 32'h0000_0003};
    vecs[1] = '{"ctrl dir only",    ADDR_CTRL,   32'h0000_0002, 32'h0000_0002};
    vecs[2] = '{"ctrl clear",       ADDR_CTRL,   32'hFFFF_FFFC, 32'h0000_0000};
    vecs[3] = '{"period truncate",  ADDR_PERIOD, 32'h1234_5678, 32'h0000_5678};
    vecs[4] = '{"duty truncate",    ADDR_DUTY,   32'hABCD_0007, 32'h0000_0007};
    vecs[5] = '{"period 10",        ADDR_PERIOD, 32'h0000_000A, 32'h0000_000A};
    vecs[6] = '{"duty 3",           ADDR_DUTY,   32'h0000_0003, 32'h0000_0003};

    reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1; address = ADDR_STATUS;
    writedata = '0; enable_in = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    tick();

    // Reset state
    check("reset pwm_out", 32'(pwm_out), 32'd0);
    check("reset dir_out", 32'(dir_out), 32'd0);
    rd(ADDR_PERIOD, got);
    check("reset PERIOD", got, 32'd1000);
    check("reset STATUS", readdata, 32'd0);

    foreach (vecs[i]) begin
      wr(vecs[i].addr, vecs[i].wdata);
      rd(vecs[i].addr, got);
      check(vecs[i].name, got, vecs[i].exp);
    end

    enable_in = 1'b1;
    #1;
    check("status enable bit", readdata, 32'h0000_0004);

    // PERIOD=10 DUTY=3, duty 3->7 written at cnt 5 of the third period
    wr(ADDR_CTRL, 32'h1);
    check("idle before run", 32'(readdata[1:0]), 32'd0);
    check("pwm before run", 32'(pwm_out), 32'd0);
    for (int i = 0; i < 40; i++) begin
      tick();
      exp_duty = (i < 30) ? 3 : 7;
      check("run pwm", 32'(pwm_out), 32'((i % 10) < exp_duty));
      check("run cnt", 32'(readdata[31:16]), 32'(i % 10));
      check("run done", 32'(readdata[STAT_DONE_BIT]), 32'(i >= 10));
      if (i == 25) begin
        chipselect = 1'b1; write_n = 1'b0; address = ADDR_DUTY; writedata = 32'd7;
      end
    end

    // DUTY >= PERIOD -> constant high
    wr(ADDR_DUTY, 32'd12);
    tick();
    wait_cnt(0, 20);
    for (int i = 0; i < 12; i++) begin
      check("duty12 high", 32'(pwm_out), 32'd1);
      tick();
    end

    // DUTY 0 -> constant low
    wr(ADDR_DUTY, 32'd0);
    tick();
    wait_cnt(0, 20);
    for (int i = 0; i < 12; i++) begin
      check("duty0 low", 32'(pwm_out), 32'd0);
      tick();
    end

    wr(ADDR_DUTY, 32'd3);
    tick();
    wait_cnt(0, 20);

    // period_done: plain clear, then clear on the wrap edge (set wins)
    wr(ADDR_STATUS, 32'h8);
    check("done cleared", 32'(readdata[STAT_DONE_BIT]), 32'd0);
    wait_cnt(9, 20);
    wr(ADDR_STATUS, 32'h8);
    check("set/clear cnt", 32'(readdata[31:16]), 32'd0);
    check("set beats clear", 32'(readdata[STAT_DONE_BIT]), 32'd1);

    // enable_in low for one cycle mid-period
    wait_cnt(1, 20);
    check("pwm high before drop", 32'(pwm_out), 32'd1);
    enable_in = 1'b0;
    tick();
    check("drop pwm low", 32'(pwm_out), 32'd0);
    check("drop state idle", 32'(readdata[2:0]), 32'd0);
    check("drop cnt", 32'(readdata[31:16]), 32'd0);
    enable_in = 1'b1;
    tick();
    check("resume state", 32'(readdata[2:0]), 32'b101);
    check("resume cnt", 32'(readdata[31:16]), 32'd0);
    check("resume pwm", 32'(pwm_out), 32'd1);
    check("resume dir", 32'(dir_out), 32'd0);

    // Direction 0->1 while running
    wr(ADDR_CTRL, 32'h3);
    check("still run after dir write", 32'(readdata[STAT_RUN_BIT]), 32'd1);
    measure_dead("dir0to1", 1'b0, 1'b1, -1, 32'h3);

    // Direction 1->0, then back to 1 during dead-time: no restart, no flip
    wait_cnt(2, 20);
    wr(ADDR_CTRL, 32'h1);
    measure_dead("dir toggle", 1'b1, 1'b1, 10, 32'h3);

    // PERIOD written to 0 while running
    wr(ADDR_PERIOD, 32'd0);
    check("period0 same cycle", 32'(readdata[STAT_RUN_BIT]), 32'd1);
    tick();
    check("period0 idle", 32'(readdata[1:0]), 32'd0);
    check("period0 pwm", 32'(pwm_out), 32'd0);
    wr(ADDR_PERIOD, 32'd10);
    tick();
    wait_cnt(1, 20);
    check("pre-reset pwm", 32'(pwm_out), 32'd1);
    check("pre-reset dir", 32'(dir_out), 32'd1);

    // Asynchronous reset mid-run
    #1 reset_n = 1'b0;
    #1;
    check("async reset pwm", 32'(pwm_out), 32'd0);
    check("async reset dir", 32'(dir_out), 32'd0);
    rd(ADDR_PERIOD, got);
    check("async reset PERIOD", got, 32'd1000);
    check("async reset STATUS", readdata, 32'h0000_0004);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();

    // Randomized traffic against the model
    for (int c = 0; c < 4000; c++) begin
      en = ($urandom_range(0, 19) != 0);
      w  = ($urandom_range(0, 7) == 0);
      a  = 2'($urandom_range(0, 3));
      case (a)
        ADDR_CTRL: begin
          ctrl_d = '0;
          ctrl_d[0] = ($urandom_range(0, 9) != 0);
          ctrl_d[1] = ($urandom_range(0, 15) == 0) ? ~m_dirreq : m_dirreq;
          d = ctrl_d;
        end
        ADDR_PERIOD: begin
          d = ($urandom_range(0, 15) == 0) ? 32'd0 : 32'($urandom_range(1, 12));
          d = d | ($urandom << 16);
        end
        ADDR_DUTY: d = 32'($urandom_range(0, 14)) | ($urandom << 16);
        default:   d = $urandom;
      endcase
      enable_in = en;
      if (w) begin
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
      end
      model_step(w, a, d, en);
      tick();
      check("rand pwm", 32'(pwm_out), 32'((m_mode == 1) && (m_pos < m_high)));
      check("rand dir", 32'(dir_out), 32'(m_dir));
      check("rand status", readdata,
            ((m_pos & 32'hFFFF) << 16) | (32'(m_done) << 3) | (32'(en) << 2) |
            (32'(m_mode == 2) << 1) | 32'(m_mode == 1));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
